shift_add_multiplier: RTL
=========================

Name: shift_add_multiplier

Overview:
Sequential 8x8 shift-and-add multiplier. It is the inverse-direction companion to the team's combinational restoring divider and shares the same operand widths, so that product/quotient pairs can be cross-checked. Operands enter on a valid/ready input handshake. The product is presented on a valid/ready output handshake and held until consumed. Both unsigned and two's-complement signed modes are supported, selected per transaction.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits wide.
CNT_W, 4, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a, b, sign_mode are valid this cycle
in_ready  output  1  block can accept operands (high only in IDLE)
sign_mode  input  1  0 = unsigned, 1 = two's-complement signed; sampled with operands
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
out_valid  output  1  product is valid and held stable
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  result a*b
busy  output  1  high in BUSY or DONE

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, counter=0, internal registers=0.
- Reset mid-operation: rst aborts any BUSY/DONE transaction with no output. The next cycle is IDLE with in_ready=1.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch the operands and go to BUSY.
  - Unsigned mode: latch |a| and |b| as the raw values.
  - Signed mode: latch magnitudes (two's-complement negate if MSB set) and neg_flag = a[MSB] XOR b[MSB].
  - Clear the accumulator; counter=WIDTH.
  - The most-negative value (-128) has magnitude 128, which fits unsigned in WIDTH bits; no special case.
- BUSY:
  - One iteration per edge, multiplier consumed LSB first.
  - If mb[0]=1: acc += ma << (WIDTH - counter), computed at 2*WIDTH bits with no truncation.
  - Then mb >>= 1 and counter -= 1.
  - On the edge where counter goes 1 -> 0, load product with acc+term, negated at 2*WIDTH bits if neg_flag=1. Set out_valid=1 and go to DONE.
  - in_valid is ignored while BUSY.
- Latency: with acceptance on edge E0, out_valid is high after edge E0+WIDTH (8 edges at default). Latency is fixed and independent of operand values, including zero operands.
- DONE:
  - out_valid=1; product is held stable while out_ready=0, for unbounded backpressure.
  - On an edge with out_ready=1: out_valid=0 and go to IDLE.
  - in_ready stays 0 in DONE, so a new operand can be accepted no earlier than the edge after the handoff.
  - Throughput is one transaction per WIDTH+2 cycles minimum.
- Arithmetic:
  - Unsigned product range is 0..(2**WIDTH-1)**2, no overflow possible.
  - Signed product range is -16256..16384 at default width; it fits in 2*WIDTH bits as two's complement.
  - A zero product in signed mode with neg_flag=1 must come out as 0 (negating 0 yields 0).
- Simultaneous events: rst takes priority over all handshakes. in_valid together with out_ready in DONE completes only the output handshake.

Decomposition:
- Shared package (mult_div_pkg): state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2; default WIDTH=8. The divider adopts this package later.
- One natural sub-module, twos_magnitude: WIDTH-bit input plus sign-enable, giving magnitude output and sign bit. It is reused for both operands at acceptance.
- Final negation stays inline.

Test Plan:
- Unsigned a=13, b=11, out_ready=1 -> out_valid rises exactly 8 edges after accept; product=16'h008F (143); back to IDLE with in_ready=1 next cycle.
- Unsigned a=255, b=255 -> product=16'hFE01. Then a=0, b=200 -> product=16'h0000 with the same 8-edge latency.
- Signed a=8'h80 (-128), b=8'h80 -> product=16'h4000. Then signed a=8'hFD (-3), b=5 -> product=16'hFFF1 (-15). Then unsigned a=8'h80, b=2 -> product=16'h0100.
- Backpressure: a=7, b=9, out_ready=0 for 20 cycles -> product=16'h003F held stable, out_valid=1, in_ready=0, and a concurrent in_valid pulse is ignored. When out_ready is raised, the handoff occurs and IDLE follows.
- Reset mid-op: accept a=50, b=3, assert rst at edge E0+4 -> next cycle out_valid=0, in_ready=1, product=0, and no stale result appears. A fresh a=6, b=7 then yields 16'h002A.
- Random cross-check: 1000 random unsigned/signed pairs against a reference model. For nonzero b, feeding (product[7:0] when product<256) into the divider recovers a.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiplier / divider pair.
// Contents:
//   DEF_WIDTH - default operand width shared by both blocks
//   state_t   - three-state handshake FSM encoding (IDLE / BUSY / DONE)
package mult_div_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_twos_magnitude.sv
// Two's-complement magnitude extractor.
// Ports:
//   value   (in,  WIDTH) operand as presented
//   sign_en (in,  1)     1 = treat value as two's complement, 0 = unsigned
//   mag     (out, WIDTH) magnitude; the most-negative value maps to 2**(WIDTH-1),
//                        which is still representable as an unsigned WIDTH-bit number
//   sign    (out, 1)     1 when sign_en is set and value is negative
module twos_magnitude #(
  parameter int WIDTH = mult_div_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             sign_en,
  output logic [WIDTH-1:0] mag,
  output logic             sign
);

  always_comb begin
    sign = sign_en & value[WIDTH-1];
    mag  = sign ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential WIDTH x WIDTH shift-and-add multiplier, unsigned or signed per
// transaction. One multiplier bit is consumed per clock, so the product
// appears a fixed WIDTH edges after the operands are accepted.
// Ports:
//   clk        (in)          rising-edge clock
//   rst        (in)          synchronous active-high reset, aborts any transaction
//   in_valid   (in)          a, b, sign_mode valid this cycle
//   in_ready   (out)         operands can be accepted (IDLE only)
//   sign_mode  (in)          0 = unsigned, 1 = two's-complement signed
//   a, b       (in,  WIDTH)  multiplicand, multiplier
//   out_valid  (out)         product valid and held stable
//   out_ready  (in)          consumer takes the product
//   product    (out, 2*WIDTH) a*b
//   busy       (out)         high in BUSY or DONE
//   fsm_state  (out, 2)      current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its data stable while valid is high and
// ready is low; valid never depends combinationally on ready.
module shift_add_multiplier
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sign_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic [1:0]           fsm_state
);

  localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] P_ONE    = {{(2*WIDTH-1){1'b0}}, 1'b1};

  state_t state, state_next;

  logic [WIDTH-1:0]   ma, mb;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg_flag;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sign_a, sign_b;

  logic [CNT_W-1:0]   shamt;
  logic [2*WIDTH-1:0] term;
  logic [2*WIDTH-1:0] sum;

  twos_magnitude #(.WIDTH(WIDTH)) u_mag_a (
    .value   (a),
    .sign_en (sign_mode),
    .mag     (mag_a),
    .sign    (sign_a)
  );

  twos_magnitude #(.WIDTH(WIDTH)) u_mag_b (
    .value   (b),
    .sign_en (sign_mode),
    .mag     (mag_b),
    .sign    (sign_b)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid)       state_next = ST_BUSY;
      ST_BUSY: if (cnt == CNT_ONE) state_next = ST_DONE;
      ST_DONE: if (out_ready)      state_next = ST_IDLE;
      default:                     state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state == ST_BUSY) || (state == ST_DONE);
    fsm_state = state;
  end

  // Partial product for this iteration. The counter runs WIDTH..1, so the
  // shift is the index of the multiplier bit currently at mb[0].
  always_comb begin
    shamt = CNT_INIT - cnt;
    term  = mb[0] ? ({{WIDTH{1'b0}}, ma} << shamt) : '0;
    sum   = acc + term;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      ma       <= '0;
      mb       <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_flag <= 1'b0;
      product  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            ma       <= mag_a;
            mb       <= mag_b;
            neg_flag <= sign_a ^ sign_b;
            acc      <= '0;
            cnt      <= CNT_INIT;
          end
        end
        ST_BUSY: begin
          acc <= sum;
          mb  <= mb >> 1;
          cnt <= cnt - CNT_ONE;
          // Final iteration: fold in the last term and apply the sign.
          // Negating zero gives zero, so no special case is needed.
          if (cnt == CNT_ONE)
            product <= neg_flag ? (~sum + P_ONE) : sum;
        end
        default: ;
      endcase
    end
  end

endmodule
